// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit multiplexed hex display scanner.
// A prescaler paces the digit scan. At each frame boundary one of four
// sources is latched, so every frame shows a single coherent value. Sources
// are chosen manually or round-robin. The scanner supports leading-zero
// blanking, a source-identifying decimal point, and blanking of the whole
// frame when no source is valid.
module seg_scan_ctrl #(
    parameter logic [15:0] DIV  = 16'd50000,
    parameter logic [7:0]  HOLD = 8'd250
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] src3,
    input  logic [3:0]  valid,
    input  logic        mode,
    input  logic [1:0]  sel,
    input  logic        blank_lz,
    output logic [7:0]  seg,
    output logic [7:0]  AN,
    output logic [1:0]  cur_src,
    output logic        frame_done
);

    logic [15:0] pcnt;
    logic [2:0]  dig;
    logic [7:0]  fcnt;
    logic [31:0] snap;
    logic        mode_q;
    logic        blank_frame;

    logic        tick;
    logic        boundary;
    logic [1:0]  auto_nxt;
    logic        auto_found;
    logic [1:0]  cand;
    logic [1:0]  new_src;
    logic [7:0]  new_fcnt;
    logic [31:0] new_snap;

    logic [3:0]  nib;
    logic [31:0] upper;
    logic        digit_blank;
    logic [6:0]  font;
    logic [7:0]  an_nxt;
    logic [7:0]  seg_nxt;

    assign tick     = (pcnt == DIV - 16'd1);
    assign boundary = tick && (dig == 3'd7);

    // Source and frame-counter decision applied at the next frame boundary
    always_comb begin
        auto_nxt   = cur_src;
        auto_found = 1'b0;
        cand       = cur_src;
        for (int unsigned k = 1; k < 4; k++) begin
            cand = cur_src + k[1:0];
            if (!auto_found && valid[cand]) begin
                auto_nxt   = cand;
                auto_found = 1'b1;
            end
        end

        new_src  = cur_src;
        new_fcnt = '0;
        if (mode) begin
            if (valid[sel]) new_src = sel;
        end else if (mode != mode_q) begin
            // Entering auto mode restarts the hold count without advancing.
            new_fcnt = '0;
        end else if (fcnt == HOLD - 8'd1) begin
            new_src  = auto_nxt;
            new_fcnt = '0;
        end else begin
            new_fcnt = fcnt + 8'd1;
        end

        case (new_src)
            2'd0:    new_snap = src0;
            2'd1:    new_snap = src1;
            2'd2:    new_snap = src2;
            default: new_snap = src3;
        endcase
    end

    // Prescaler, digit scan, and frame-boundary state updates
    always_ff @(posedge clk) begin
        if (clr) begin
            pcnt        <= '0;
            dig         <= '0;
            fcnt        <= '0;
            cur_src     <= '0;
            snap        <= '0;
            mode_q      <= 1'b0;
            blank_frame <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                pcnt <= '0;
                dig  <= dig + 3'd1;
            end else begin
                pcnt <= pcnt + 16'd1;
            end
            if (boundary) begin
                cur_src     <= new_src;
                fcnt        <= new_fcnt;
                snap        <= new_snap;
                mode_q      <= mode;
                blank_frame <= (valid == 4'b0000);
            end
        end
    end

    // Digit decode: nibble font, blanking, and decimal-point marker
    always_comb begin
        nib         = snap[{dig, 2'b00} +: 4];
        upper       = snap >> {dig, 2'b00};
        digit_blank = blank_frame || (blank_lz && (dig != 3'd0) && (upper == '0));
        case (nib)
            4'h0:    font = 7'b0000001;
            4'h1:    font = 7'b1001111;
            4'h2:    font = 7'b0010010;
            4'h3:    font = 7'b0000110;
            4'h4:    font = 7'b1001100;
            4'h5:    font = 7'b0100100;
            4'h6:    font = 7'b0100000;
            4'h7:    font = 7'b0001111;
            4'h8:    font = 7'b0000000;
            4'h9:    font = 7'b0000100;
            4'hA:    font = 7'b0001000;
            4'hB:    font = 7'b1100000;
            4'hC:    font = 7'b0110001;
            4'hD:    font = 7'b1000010;
            4'hE:    font = 7'b0110000;
            default: font = 7'b0111000;
        endcase
        seg_nxt = {font, (dig == {1'b0, cur_src}) ? 1'b0 : 1'b1};
        an_nxt  = digit_blank ? '1 : ~(8'd1 << dig);
    end

    // Registered display drive, one clock behind dig/snap
    always_ff @(posedge clk) begin
        if (clr) begin
            AN  <= '1;
            seg <= '1;
        end else begin
            AN  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=4, HOLD=2 (one frame = 32 clocks).
module tb_seg_scan_ctrl;

    logic        clk;
    logic        clr;
    logic [31:0] src0, src1, src2, src3;
    logic [3:0]  valid;
    logic        mode;
    logic [1:0]  sel;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [7:0]  AN;
    logic [1:0]  cur_src;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int n = 0;

    seg_scan_ctrl #(.DIV(16'd4), .HOLD(8'd2)) dut (
        .clk(clk), .clr(clr),
        .src0(src0), .src1(src1), .src2(src2), .src3(src3),
        .valid(valid), .mode(mode), .sel(sel), .blank_lz(blank_lz),
        .seg(seg), .AN(AN), .cur_src(cur_src), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // n counts rising edges since the last reset edge; sampling is on negedges.
    task automatic step(input int k);
        repeat (k) @(negedge clk);
        n += k;
    endtask

    task automatic goto(input int t);
        step(t - n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
    endtask

    initial begin
        clr = 1'b1;
        src0 = '0; src1 = '0; src2 = '0; src3 = '0;
        valid = 4'hF; mode = 1'b0; sel = 2'd0; blank_lz = 1'b0;

        // Reset state, digit walk, frame_done period
        do_reset();
        check("rst_AN", AN, 8'hFF);
        check("rst_seg", seg, 8'hFF);
        check("rst_cur", cur_src, 2'd0);
        check("rst_fd", frame_done, 1'b0);
        for (int e = 1; e <= 68; e++) begin
            goto(e);
            check("walk_AN", AN, 8'hFF ^ (8'h01 << (((e - 1) / 4) % 8)));
            check("walk_fd", frame_done, (e % 32 == 0) ? 1'b1 : 1'b0);
            if (e == 1) check("first_seg0", seg, 8'h02);
        end

        // Manual select, leading-zero blanking, mid-frame source change
        mode = 1'b1; sel = 2'd2; valid = 4'hF; blank_lz = 1'b1;
        src2 = 32'h0000_12AB;
        do_reset();
        goto(1);  check("lz0_AN", AN, 8'hFE); check("lz0_seg", seg, 8'h02);
        goto(5);  check("lz1_AN", AN, 8'hFF);
        goto(32); check("man_cur", cur_src, 2'd2);
        goto(33); check("m_d0_AN", AN, 8'hFE); check("m_d0_seg", seg, 8'hC1);
        goto(34); src2 = 32'hFFFF_FFFF;
        goto(37); check("m_d1_AN", AN, 8'hFD); check("m_d1_seg", seg, 8'h11);
        goto(41); check("m_d2_AN", AN, 8'hFB); check("m_d2_seg", seg, 8'h24);
        goto(45); check("m_d3_AN", AN, 8'hF7); check("m_d3_seg", seg, 8'h9F);
        for (int e = 49; e <= 61; e += 4) begin
            goto(e); check("m_hi_AN", AN, 8'hFF);
        end
        goto(64); check("m_fd", frame_done, 1'b1);
        goto(65); check("new_d0_AN", AN, 8'hFE); check("new_d0_seg", seg, 8'h71);
        goto(73); check("new_d2_seg", seg, 8'h70);

        // Auto round-robin over valid=1010
        mode = 1'b0; sel = 2'd0; valid = 4'b1010; blank_lz = 1'b0;
        src1 = 32'h0000_0005; src2 = '0;
        do_reset();
        goto(32);  check("rr_b1", cur_src, 2'd0);
        goto(64);  check("rr_b2", cur_src, 2'd1);
        goto(65);  check("rr_seg", seg, 8'h49);
        goto(96);  check("rr_b3", cur_src, 2'd1);
        goto(128); check("rr_b4", cur_src, 2'd3);
        goto(160); check("rr_b5", cur_src, 2'd3);
        goto(192); check("rr_b6", cur_src, 2'd1);

        // valid=0 at a boundary blanks the whole next frame
        mode = 1'b1; sel = 2'd3; valid = 4'hF; src3 = 32'h8765_4321;
        do_reset();
        goto(32); check("vb_cur", cur_src, 2'd3);
        goto(33); valid = 4'h0;
        goto(37); check("vb_mid_AN", AN, 8'hFD);
        for (int e = 65; e <= 93; e += 4) begin
            goto(e); check("vb_AN", AN, 8'hFF);
        end
        check("vb_hold", cur_src, 2'd3);
        valid = 4'hF;
        goto(97); check("vb_back_AN", AN, 8'hFE);

        // Reset pulse at dig=5 aborts the frame
        mode = 1'b1; sel = 2'd1; valid = 4'hF;
        do_reset();
        goto(32); check("ab_cur", cur_src, 2'd1);
        goto(54); check("ab_pre_AN", AN, 8'hDF);
        clr = 1'b1;
        goto(55);
        clr = 1'b0;
        check("ab_AN", AN, 8'hFF);
        check("ab_seg", seg, 8'hFF);
        check("ab_cur0", cur_src, 2'd0);
        n = 0;
        for (int e = 1; e <= 32; e++) begin
            goto(e);
            check("ab_fd", frame_done, (e == 32) ? 1'b1 : 1'b0);
            if (e == 1) begin
                check("ab_re_AN", AN, 8'hFE);
                check("ab_re_seg", seg, 8'h02);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
